sw_led_ctrl: RTL and testbench
==============================

# sw_led_ctrl

Parametrised switch-input and LED-output controller for the board I/O panel, running in the `sys_clk` domain produced by the clock manager. Each of `N_CH` switch channels is synchronised, debounced and edge-detected; debounced levels and edge pulses are exported to the core. LEDs are driven from the debounced switches in one of four run-time modes: direct follow, toggle-on-press, blink and hold.

## Interface
- `N_CH`, 8: number of switch/LED channels, at least 1.
- `DEBOUNCE_CYCLES`, 450000: cycles a synchronised level must stay stable before it is accepted; at least 1. The default is 1 ms at 450 MHz.
- `BLINK_DIV`, 225000000: cycles per blink half-period, at least 1. Used only when `SW_LED_BLINK_EN` is defined.

Ports:
- `sys_clk`, in, 1: system clock. Everything is rising-edge.
- `reset_n`, in, 1: reset, asynchronous, active-low (decided).
- `sw`, in, [0:N_CH-1]: raw, asynchronous switch inputs.
- `mode`, in, 2: LED mode. 00 DIRECT, 01 TOGGLE, 10 BLINK, 11 HOLD. Synchronous to `sys_clk`.
- `sw_db`, out, [0:N_CH-1]: debounced switch levels.
- `sw_rise`, out, [0:N_CH-1]: one-cycle pulse on a 0→1 transition of `sw_db`.
- `sw_fall`, out, [0:N_CH-1]: one-cycle pulse on a 1→0 transition of `sw_db`.
- `led`, out, [0:N_CH-1]: registered LED drive.

## Operation
- **Reset.** While `reset_n` is low, every flop is 0: synchronisers, counters, `sw_db`, `sw_rise`, `sw_fall`, `led`, the blink prescaler and the blink phase. Reset takes effect immediately, with no clock edge.
- **Synchroniser.** Each channel has a two-flop synchroniser; its output is `s[i]`.
- **Debounce counter.** Each channel has its own counter, width `$clog2(DEBOUNCE_CYCLES+1)`.
  - If `s[i] == sw_db[i]`: the counter is 0.
  - Otherwise, if the counter equals `DEBOUNCE_CYCLES-1`: `sw_db[i]` ← `s[i]`, the counter ← 0, and the matching edge pulse is set for exactly one cycle.
  - Otherwise the counter increments.
  - Any return of `s[i]` to `sw_db[i]` clears the count, so glitches shorter than `DEBOUNCE_CYCLES` produce no change and no pulse.
- **Pulses.** `sw_rise` and `sw_fall` are registered and are 0 in every cycle without an accepted transition. They are never both set on the same channel.
- **LED register.** It updates every edge from the registered `sw_db`, `sw_rise` and blink phase:
  - DIRECT: `led` ← `sw_db`.
  - TOGGLE: `led[i]` ← `led[i] ^ sw_rise[i]`. `sw_fall` has no effect.
  - BLINK: `led` ← `sw_db` & {N_CH{phase}}.
  - HOLD: `led` ← `led`. Debouncing and pulses continue.
- **Mode changes** take effect at the next edge. Entering TOGGLE or HOLD starts from the current `led` value; there is no clear.
- **Channels** are fully independent. Simultaneous transitions on several channels each produce their own pulse in the same cycle.
- **Switches high at reset release** are accepted through normal debounce and do produce `sw_rise`.

## Timing
- Raw `sw` first sampled at edge k and held stable:
  - `s` changes at edge k+1.
  - `sw_db` and the pulse are set at edge k+1+`DEBOUNCE_CYCLES`.
  - `led` changes one edge later in DIRECT or BLINK mode.
- Total switch-to-LED latency is `DEBOUNCE_CYCLES`+2 cycles after first sampling.
- Each pulse is exactly one cycle wide.
- Blink prescaler:
  - Counts 0..`BLINK_DIV-1`, then wraps to 0.
  - The phase toggles on the wrap edge, so the phase is high for `BLINK_DIV` cycles and low for `BLINK_DIV` cycles.
  - It runs continuously in every mode, so the phase on entering BLINK is arbitrary.
- The debounce counter never exceeds `DEBOUNCE_CYCLES-1`. With `DEBOUNCE_CYCLES`=1, a synchronised change is accepted on the first mismatching edge.

## Configuration
- `SW_LED_BLINK_EN` defined: the blink prescaler and phase are built, and mode 10 blinks as described above.
- `SW_LED_BLINK_EN` undefined:
  - No prescaler or phase logic is built, and `BLINK_DIV` is ignored.
  - Mode 10 behaves exactly as DIRECT.
  - All other behaviour is unchanged.

## Test plan
All scenarios use `N_CH`=8, `DEBOUNCE_CYCLES`=4 and `BLINK_DIV`=8.
- **Reset and power-up accept.** Hold `sw`=8'hFF and `mode`=00 through reset, release at edge 0 → all outputs 0 during reset; `sw_db`=FF and `sw_rise`=FF at edge 5; `sw_rise`=00 at edge 6; `led`=FF at edge 6.
- **Glitch reject.** Raise `sw[3]` for 3 cycles, then drop it → `sw_db`, `sw_rise`, `sw_fall` and `led` never change. Then hold `sw[3]` for 10 cycles → exactly one `sw_rise[3]` pulse, and `sw_db[3]`=1 five edges after first sampling.
- **Toggle.** With `mode`=01 and `led`=0, give `sw[0]` two press/release pulses of 10 cycles each → `led[0]` goes 0→1 after press 1 and 1→0 after press 2. Releases cause no change; `sw_fall[0]` pulses twice.
- **Blink.** With `mode`=10 and `sw[4:7]` high, wait 40 cycles:
  - Macro defined → `led` alternates between `sw[4:7]` lit and all off, every 8 cycles.
  - Macro undefined → `led` stays at `sw[4:7]` lit.
- **Hold.** With `mode`=11 and `led`=FF, drive `sw`=00 → `sw_db` reaches 00 and `sw_fall`=FF pulses once, while `led` stays FF. Switching to `mode`=00 gives `led`=00 one edge later.
- **Asynchronous reset mid-debounce.** Start a `sw[1]` transition and pull `reset_n` low between clock edges after counting 2 cycles → all outputs 0 immediately. After release, a fresh full 4-cycle debounce is required before `sw_db[1]` changes.

Source files
------------

// File: rtl/sw_led_ctrl_if.sv
// sw_led_ctrl_if: switch/LED panel bus between the I/O controller and the core.
// Signal semantics (no handshake on this bus): sw is raw and asynchronous,
// mode is synchronous to sys_clk, and every output is registered and valid
// on every cycle.
// The slave modport is the controller side; the master modport is the core side.
interface sw_led_ctrl_if #(
    parameter int N_CH = 8
) ();
    logic [0:N_CH-1] sw;
    logic [1:0]      mode;
    logic [0:N_CH-1] sw_db;
    logic [0:N_CH-1] sw_rise;
    logic [0:N_CH-1] sw_fall;
    logic [0:N_CH-1] led;

    modport master (
        output sw,
        output mode,
        input  sw_db,
        input  sw_rise,
        input  sw_fall,
        input  led
    );

    modport slave (
        input  sw,
        input  mode,
        output sw_db,
        output sw_rise,
        output sw_fall,
        output led
    );
endinterface

// File: rtl/sw_led_ctrl.sv
// sw_led_ctrl: per-channel switch synchroniser, debouncer and edge detector,
// plus a registered LED driver with DIRECT / TOGGLE / BLINK / HOLD modes.
// Optional feature macro: SW_LED_BLINK_EN. When it is defined, the blink prescaler
// and phase are built. When it is undefined, the BLINK mode behaves as DIRECT.
module sw_led_ctrl #(
    parameter int N_CH            = 8,
    parameter int DEBOUNCE_CYCLES = 450000,
    parameter int BLINK_DIV       = 225000000
) (
    input  logic         sys_clk,
    input  logic         reset_n,
    sw_led_ctrl_if.slave bus
);
    localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_TOGGLE = 2'b01;
    localparam logic [1:0] MODE_BLINK  = 2'b10;
    localparam logic [1:0] MODE_HOLD   = 2'b11;

    // Reject nonsensical parameter sets at elaboration
    if (N_CH < 1 || DEBOUNCE_CYCLES < 1 || BLINK_DIV < 1) begin : g_param_check
        $error("sw_led_ctrl: N_CH, DEBOUNCE_CYCLES and BLINK_DIV must all be >= 1");
    end

    logic [0:N_CH-1] sync1_q;
    logic [0:N_CH-1] sync2_q;
    logic [0:N_CH-1] db_q,   db_d;
    logic [0:N_CH-1] rise_q, rise_d;
    logic [0:N_CH-1] fall_q, fall_d;
    logic [0:N_CH-1] led_q,  led_d;
    logic [CW-1:0]   cnt_q [N_CH];
    logic [CW-1:0]   cnt_d [N_CH];
    logic            phase;

    // Two-flop synchroniser for the raw asynchronous switches
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.sw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: count consecutive mismatches, accept on the DEBOUNCE_CYCLES-th one
    always_comb begin
        db_d   = db_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    db_d[i]   = sync2_q[i];
                    rise_d[i] = sync2_q[i];
                    fall_d[i] = ~sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Debounce counters, accepted levels and one-cycle edge pulses
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            db_q   <= '0;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            db_q   <= db_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

`ifdef SW_LED_BLINK_EN
    localparam int            BW        = $clog2(BLINK_DIV + 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q,     phase_d;

    // Free-running prescaler; phase flips on every wrap, in every mode
    always_comb begin
        blink_cnt_d = blink_cnt_q + 1'b1;
        phase_d     = phase_q;
        if (blink_cnt_q == BLINK_MAX) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    // Prescaler and phase registers
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign phase = phase_q;
`else
    // Without the prescaler the blink mask is all ones, so BLINK equals DIRECT
    assign phase = 1'b1;
`endif

    // LED next value from the registered debounce outputs and the current mode
    always_comb begin
        led_d = led_q;
        case (bus.mode)
            MODE_DIRECT: led_d = db_q;
            MODE_TOGGLE: led_d = led_q ^ rise_q;
            MODE_BLINK:  led_d = db_q & {N_CH{phase}};
            MODE_HOLD:   led_d = led_q;
            default:     led_d = led_q;
        endcase
    end

    // LED drive register
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            led_q <= '0;
        end else begin
            led_q <= led_d;
        end
    end

    assign bus.sw_db   = db_q;
    assign bus.sw_rise = rise_q;
    assign bus.sw_fall = fall_q;
    assign bus.led     = led_q;
endmodule

// File: tb/tb_sw_led_ctrl.sv
// tb_sw_led_ctrl: directed bench for sw_led_ctrl with N_CH=8, DEBOUNCE_CYCLES=4, BLINK_DIV=8.
// A behavioural model (sample delay line, mismatch streaks, edge-count blink phase)
// is compared against the DUT on every falling edge, and hand-computed literals
// pin the key scenario points.
module tb_sw_led_ctrl;
    localparam int N  = 8;
    localparam int D  = 4;
    localparam int BD = 8;

    logic sys_clk = 1'b0;
    logic reset_n = 1'b1;

    sw_led_ctrl_if #(.N_CH(N)) bus ();

    sw_led_ctrl #(
        .N_CH(N),
        .DEBOUNCE_CYCLES(D),
        .BLINK_DIV(BD)
    ) dut (
        .sys_clk(sys_clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    // Clock
    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [0:N-1] act, input logic [0:N-1] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: raw samples reach the debouncer two edges later; a level is
    // accepted after D consecutive edges of disagreement; blink phase is derived from
    // the number of edges since reset.
    logic [0:N-1] m_pipe [2];
    int           streak [N];
    logic [0:N-1] m_db   = '0;
    logic [0:N-1] m_rise = '0;
    logic [0:N-1] m_fall = '0;
    logic [0:N-1] m_led  = '0;
    int           n_edges = 0;
    logic         old_phase;

    always @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            m_pipe[0] = '0;
            m_pipe[1] = '0;
            m_db      = '0;
            m_rise    = '0;
            m_fall    = '0;
            m_led     = '0;
            n_edges   = 0;
            for (int i = 0; i < N; i++) streak[i] = 0;
        end else begin
`ifdef SW_LED_BLINK_EN
            old_phase = ((n_edges / BD) % 2) == 1;
`else
            old_phase = 1'b1;
`endif
            case (bus.mode)
                2'b00:   m_led = m_db;
                2'b01:   m_led = m_led ^ m_rise;
                2'b10:   m_led = m_db & {N{old_phase}};
                default: m_led = m_led;
            endcase
            m_rise = '0;
            m_fall = '0;
            for (int i = 0; i < N; i++) begin
                if (m_pipe[1][i] != m_db[i]) begin
                    streak[i]++;
                    if (streak[i] == D) begin
                        m_db[i]   = m_pipe[1][i];
                        m_rise[i] = m_db[i];
                        m_fall[i] = ~m_db[i];
                        streak[i] = 0;
                    end
                end else begin
                    streak[i] = 0;
                end
            end
            m_pipe[1] = m_pipe[0];
            m_pipe[0] = bus.sw;
            n_edges++;
        end
    end

    // Scoreboard compare on every falling edge
    always @(negedge sys_clk) begin
        chk("cmp_db",   bus.sw_db,   m_db);
        chk("cmp_rise", bus.sw_rise, m_rise);
        chk("cmp_fall", bus.sw_fall, m_fall);
        chk("cmp_led",  bus.led,     m_led);
    end

    // Pulse tallies used by the directed checks
    int rise3_cnt    = 0;
    int fall0_cnt    = 0;
    int fall_all_cnt = 0;
    always @(negedge sys_clk) begin
        if (bus.sw_rise[3]) rise3_cnt++;
        if (bus.sw_fall[0]) fall0_cnt++;
        if (bus.sw_fall == 8'hFF) fall_all_cnt++;
    end

    int           snap;
    int           toggles;
    int           stray;
    logic [0:N-1] prev_led;

    initial begin
        bus.sw   = 8'hFF;
        bus.mode = 2'b00;
        #1 reset_n = 1'b0;

        // Reset and power-up accept
        repeat (3) @(negedge sys_clk);
        chk("rst_db",   bus.sw_db,   8'h00);
        chk("rst_rise", bus.sw_rise, 8'h00);
        chk("rst_fall", bus.sw_fall, 8'h00);
        chk("rst_led",  bus.led,     8'h00);
        reset_n = 1'b1;
        repeat (6) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("pu_db_e5",   bus.sw_db,   8'hFF);
        chk("pu_rise_e5", bus.sw_rise, 8'hFF);
        chk("pu_led_e5",  bus.led,     8'h00);
        @(negedge sys_clk);
        chk("pu_rise_e6", bus.sw_rise, 8'h00);
        chk("pu_led_e6",  bus.led,     8'hFF);

        // Glitch reject on sw[3], then a real press
        bus.sw = 8'h00;
        repeat (10) @(negedge sys_clk);
        chk("gl_idle_db", bus.sw_db, 8'h00);
        snap = rise3_cnt;
        bus.sw[3] = 1'b1;
        repeat (3) @(negedge sys_clk);
        bus.sw[3] = 1'b0;
        repeat (10) @(negedge sys_clk);
        chk("gl_db", bus.sw_db, 8'h00);
        chk("gl_led", bus.led, 8'h00);
        chk_int("gl_rise_count", rise3_cnt - snap, 0);
        snap = rise3_cnt;
        bus.sw[3] = 1'b1;
        repeat (5) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("press_db_e4", bus.sw_db, 8'h00);
        @(negedge sys_clk);
        chk("press_db_e5", bus.sw_db, 8'h10);
        repeat (8) @(negedge sys_clk);
        chk_int("press_rise_count", rise3_cnt - snap, 1);

        // Toggle on sw[0]
        bus.sw = 8'h00;
        repeat (10) @(negedge sys_clk);
        chk("tg_start_led", bus.led, 8'h00);
        bus.mode = 2'b01;
        snap = fall0_cnt;
        for (int p = 0; p < 2; p++) begin
            bus.sw[0] = 1'b1;
            repeat (10) @(negedge sys_clk);
            chk("tg_after_press", bus.led, (p == 0) ? 8'h80 : 8'h00);
            bus.sw[0] = 1'b0;
            repeat (10) @(negedge sys_clk);
            chk("tg_after_release", bus.led, (p == 0) ? 8'h80 : 8'h00);
        end
        chk_int("tg_fall_count", fall0_cnt - snap, 2);

        // Blink with sw[4:7] high
        bus.mode = 2'b10;
        bus.sw   = 8'h0F;
        repeat (10) @(negedge sys_clk);
        prev_led = bus.led;
        toggles  = 0;
        stray    = 0;
        for (int c = 0; c < 32; c++) begin
            @(negedge sys_clk);
            if (bus.led != prev_led) toggles++;
            if (bus.led != 8'h0F && bus.led != 8'h00) stray++;
            prev_led = bus.led;
        end
        chk_int("bl_stray_values", stray, 0);
`ifdef SW_LED_BLINK_EN
        chk_int("bl_toggles", toggles, 4);
`else
        chk_int("bl_toggles", toggles, 0);
        chk("bl_led_steady", bus.led, 8'h0F);
`endif

        // Hold
        bus.mode = 2'b00;
        bus.sw   = 8'hFF;
        repeat (10) @(negedge sys_clk);
        chk("hd_start_led", bus.led, 8'hFF);
        bus.mode = 2'b11;
        snap = fall_all_cnt;
        bus.sw = 8'h00;
        repeat (10) @(negedge sys_clk);
        chk("hd_db", bus.sw_db, 8'h00);
        chk("hd_led", bus.led, 8'hFF);
        chk_int("hd_fall_count", fall_all_cnt - snap, 1);
        bus.mode = 2'b00;
        @(negedge sys_clk);
        chk("hd_exit_led", bus.led, 8'h00);

        // Asynchronous reset in the middle of a sw[1] debounce
        bus.sw = 8'h80;
        repeat (10) @(negedge sys_clk);
        chk("ar_pre_db", bus.sw_db, 8'h80);
        chk("ar_pre_led", bus.led, 8'h80);
        bus.sw = 8'hC0;
        repeat (4) @(posedge sys_clk);
        #2 reset_n = 1'b0;
        #1;
        chk("ar_db",   bus.sw_db,   8'h00);
        chk("ar_rise", bus.sw_rise, 8'h00);
        chk("ar_fall", bus.sw_fall, 8'h00);
        chk("ar_led",  bus.led,     8'h00);
        repeat (2) @(negedge sys_clk);
        reset_n = 1'b1;
        repeat (5) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("ar_post_db_e4", bus.sw_db, 8'h00);
        @(negedge sys_clk);
        chk("ar_post_db_e5", bus.sw_db, 8'hC0);

        repeat (3) @(negedge sys_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
